// File: rtl/dmem_access_controller_if.sv
// rtl/dmem_access_controller_if.sv - pipeline request/response and data-memory bus bundle
interface dmem_access_controller_if;
  // MEM-stage request
  logic        ReqRead;
  logic        ReqWrite;
  logic [31:0] ReqAddress;
  logic [31:0] ReqWriteData;
  // MEM-stage response
  logic        Stall;
  logic [31:0] ReadData_out;
  logic        Done;
  logic        AccessFault;
  logic        AlignFault;
  logic [15:0] MissCount;
  // data-memory bus
  logic        memRead;
  logic        memWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        DMemError;

  // controller view: consumes requests and memory responses, drives everything else
  modport master (
    input  ReqRead, ReqWrite, ReqAddress, ReqWriteData, ReadData, DMemError,
    output Stall, ReadData_out, Done, AccessFault, AlignFault, MissCount,
    output memRead, memWrite, Address, WriteData
  );

  // environment view: pipeline plus data memory
  modport slave (
    output ReqRead, ReqWrite, ReqAddress, ReqWriteData, ReadData, DMemError,
    input  Stall, ReadData_out, Done, AccessFault, AlignFault, MissCount,
    input  memRead, memWrite, Address, WriteData
  );
endinterface

// File: rtl/dmem_access_controller.sv
// rtl/dmem_access_controller.sv - data-memory initiator with miss stall, timed retry and fault reporting
module dmem_access_controller #(
  parameter int unsigned MISS_PENALTY = 4,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter logic [31:0] FAULT_DATA   = 32'hBAD0DADA
) (
  input logic                       Clk,
  input logic                       Rst,
  dmem_access_controller_if.master  bus
);

  localparam int unsigned PW = $clog2(MISS_PENALTY + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 2);
  localparam logic [PW-1:0] PENALTY_LOAD = PW'(MISS_PENALTY);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCESS    = 2'd1,
    S_MISS_WAIT = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_op_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [RW-1:0] r_retry;
  logic [PW-1:0] r_penalty;
  logic [15:0]   r_miss_count;
  logic          r_access_fault;
  logic          r_align_fault;

  logic w_req;
  logic w_misaligned;
  logic w_stall;
  logic w_mem_read;
  logic w_mem_write;

  assign w_req        = bus.ReqRead || bus.ReqWrite;
  assign w_misaligned = (bus.ReqAddress[1:0] != 2'b00);

  // State register; reset abandons any access in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus the combinational stall and memory strobes; a missed store never reaches memWrite.
  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          w_next  = w_misaligned ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_stall     = 1'b1;
        w_mem_read  = !r_op_write;
        w_mem_write = r_op_write && !bus.DMemError;
        if (!bus.DMemError)          w_next = S_DONE;
        else if (r_retry < RETRY_MAX) w_next = S_MISS_WAIT;
        else                          w_next = S_DONE;
      end
      S_MISS_WAIT: begin
        w_stall = 1'b1;
        if (r_penalty <= PW'(1)) w_next = S_ACCESS;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, load capture, retry/penalty counting and miss statistics.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_op_write     <= 1'b0;
      r_addr         <= 32'd0;
      r_wdata        <= 32'd0;
      r_rdata        <= 32'd0;
      r_retry        <= '0;
      r_penalty      <= '0;
      r_miss_count   <= 16'd0;
      r_access_fault <= 1'b0;
      r_align_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_op_write     <= bus.ReqWrite;
            r_addr         <= bus.ReqAddress;
            r_wdata        <= bus.ReqWriteData;
            r_retry        <= '0;
            r_access_fault <= 1'b0;
            r_align_fault  <= w_misaligned;
          end
        end
        S_ACCESS: begin
          if (!bus.DMemError) begin
            if (!r_op_write) r_rdata <= bus.ReadData;
          end else begin
            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
            if (r_retry < RETRY_MAX) begin
              r_retry   <= r_retry + RW'(1);
              r_penalty <= PENALTY_LOAD;
            end else begin
              r_rdata        <= FAULT_DATA;
              r_access_fault <= 1'b1;
            end
          end
        end
        S_MISS_WAIT: r_penalty <= r_penalty - PW'(1);
        default: ;
      endcase
    end
  end

  assign bus.Stall        = w_stall;
  assign bus.Done         = (r_state == S_DONE);
  assign bus.AccessFault  = (r_state == S_DONE) && r_access_fault;
  assign bus.AlignFault   = (r_state == S_DONE) && r_align_fault;
  assign bus.ReadData_out = r_rdata;
  assign bus.MissCount    = r_miss_count;
  assign bus.memRead      = w_mem_read;
  assign bus.memWrite     = w_mem_write;
  assign bus.Address      = r_addr;
  assign bus.WriteData    = r_wdata;

endmodule
